// File: rtl/bd_word_router_pkg.sv
// Shared types, default leaf codes and sizing helpers for the BD word router.
package BDRouterPkg;

    localparam int unsigned NBDCODE_DEF    = 4;
    localparam int unsigned NBDPAYLOAD_DEF = 32;

    // Default leaf codes for register-readback accumulator and tag-ack traffic
    localparam logic [NBDCODE_DEF-1:0] RO_ACC = 4'd11;
    localparam logic [NBDCODE_DEF-1:0] RO_TAT = 4'd12;

    typedef struct packed {
        logic [NBDCODE_DEF-1:0]    leaf_code;
        logic [NBDPAYLOAD_DEF-1:0] payload;
    } bd_word_t;

    // Width needed to hold an occupancy value in the range 0..depth
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bd_word_router_fifo.sv
// Per-output FIFO for the BD word router. The full flag is registered so the
// router's input acknowledge never depends combinationally on out_a.
module bd_route_fifo
    import BDRouterPkg::*;
#(
    parameter int unsigned W     = 36,
    parameter int unsigned Depth = 4,
    localparam int unsigned CW   = occ_width(Depth)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    output logic          full,
    output logic          out_v,
    input  logic          out_a,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(Depth);

    logic [W-1:0]  r_mem [Depth];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    // A full FIFO refuses a push even if it is popped in the same cycle
    assign w_push = push & ~r_full;
    assign w_pop  = out_v & out_a;

    // Next occupancy: +1 on push only, -1 on pop only, unchanged on both
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Storage write; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered full flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(Depth));
        end
    end

    assign full  = r_full;
    assign out_v = (r_count != '0);
    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/bd_word_router.sv
// BD word router: steers each decoded word to the outputs selected by its
// leaf code's route mask, with one FIFO per output. Words with an all-zero
// mask are acknowledged, discarded and counted.
module bd_word_router
    import BDRouterPkg::*;
#(
    parameter int unsigned NBDpayload = 32,
    parameter int unsigned NBDcode    = 4,
    parameter int unsigned Nout       = 4,
    parameter int unsigned Depth      = 4,
    parameter int unsigned Ncnt       = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [(2**NBDcode)*Nout-1:0]          conf_route,
    input  logic                                  in_v,
    input  logic [NBDcode-1:0]                    in_leaf_code,
    input  logic [NBDpayload-1:0]                 in_payload,
    output logic                                  in_a,
    output logic [Nout-1:0]                       out_v,
    output logic [Nout*(NBDcode+NBDpayload)-1:0]  out_data,
    input  logic [Nout-1:0]                       out_a,
    output logic [Ncnt-1:0]                       drop_count,
    output logic [Nout*occ_width(Depth)-1:0]      fifo_count
);

    localparam int unsigned W      = NBDcode + NBDpayload;
    localparam int unsigned CW     = occ_width(Depth);
    localparam int unsigned NCODES = 2**NBDcode;

    logic [Nout-1:0]          w_mask;
    logic [Nout-1:0]          w_full;
    logic [Nout-1:0]          w_push;
    logic                     w_xfer;
    logic                     w_drop;
    logic [Nout-1:0][W-1:0]   w_dout;
    logic [Nout-1:0][CW-1:0]  w_count;
    logic [Ncnt-1:0]          r_drop_count;

    // Route-mask lookup for the presented leaf code
    always_comb begin
        w_mask = '0;
        for (int unsigned c = 0; c < NCODES; c++) begin
            if (in_leaf_code == NBDcode'(c)) begin
                w_mask = conf_route[c*Nout +: Nout];
            end
        end
    end

    // Accept only when every selected output has room; held low in reset
    assign in_a   = reset & in_v & (&(~w_mask | ~w_full));
    assign w_xfer = in_v & in_a;
    assign w_drop = w_xfer & ~(|w_mask);
    assign w_push = {Nout{w_xfer}} & w_mask;

    for (genvar k = 0; k < Nout; k++) begin : g_out
        bd_route_fifo #(
            .W     (W),
            .Depth (Depth)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (w_push[k]),
            .din   ({in_leaf_code, in_payload}),
            .full  (w_full[k]),
            .out_v (out_v[k]),
            .out_a (out_a[k]),
            .dout  (w_dout[k]),
            .count (w_count[k])
        );
    end

    // Saturating count of words discarded for an all-zero route mask
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign out_data   = w_dout;
    assign fifo_count = w_count;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_bd_word_router.sv
// Self-checking bench for bd_word_router: directed scenarios followed by a
// randomized run, all checked against a queue-based reference model.
module tb_bd_word_router;
    import BDRouterPkg::*;

    localparam int unsigned NOUT  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NCNT  = 4;
    localparam int unsigned CW    = 3;
    localparam int unsigned WW    = 36;
    localparam int unsigned DMAX  = (1 << NCNT) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [63:0]          conf_route;
    logic                 in_v;
    logic [3:0]           in_leaf_code;
    logic [31:0]          in_payload;
    logic                 in_a;
    logic [NOUT-1:0]      out_v;
    logic [NOUT*WW-1:0]   out_data;
    logic [NOUT-1:0]      out_a;
    logic [NCNT-1:0]      drop_count;
    logic [NOUT*CW-1:0]   fifo_count;

    bd_word_router #(
        .NBDpayload (32),
        .NBDcode    (4),
        .Nout       (NOUT),
        .Depth      (DEPTH),
        .Ncnt       (NCNT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .conf_route   (conf_route),
        .in_v         (in_v),
        .in_leaf_code (in_leaf_code),
        .in_payload   (in_payload),
        .in_a         (in_a),
        .out_v        (out_v),
        .out_data     (out_data),
        .out_a        (out_a),
        .drop_count   (drop_count),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    bd_word_t    q [NOUT][$];
    int unsigned m_drops = 0;
    bit          model_valid = 1'b0;
    logic        obs_in_a;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_route(input logic [3:0] code, input logic [3:0] mask);
        conf_route[{code, 2'b00} +: 4] = mask;
    endtask

    // One clock cycle: check outputs and in_a against the model, then advance it
    task automatic cycle();
        logic [3:0] m;
        bit         fits;
        bit         acc;
        bd_word_t   w;
        #1;
        m    = conf_route[{in_leaf_code, 2'b00} +: 4];
        fits = 1'b1;
        for (int k = 0; k < NOUT; k++) begin
            if (m[k] && q[k].size() >= DEPTH) fits = 1'b0;
        end
        acc      = reset && in_v && fits;
        obs_in_a = in_a;
        check("in_a", in_a, acc);
        if (model_valid) begin
            for (int k = 0; k < NOUT; k++) begin
                check($sformatf("out_v[%0d]", k), out_v[k], q[k].size() != 0);
                check($sformatf("fifo_count[%0d]", k), fifo_count[k*CW +: CW], q[k].size());
                if (q[k].size() != 0) begin
                    check($sformatf("out_data[%0d]", k), out_data[k*WW +: WW], q[k][0]);
                end
            end
            check("drop_count", drop_count, m_drops);
        end
        @(posedge clk);
        if (!reset) begin
            for (int k = 0; k < NOUT; k++) q[k].delete();
            m_drops     = 0;
            model_valid = 1'b1;
        end else begin
            for (int k = 0; k < NOUT; k++) begin
                if (out_a[k] && q[k].size() != 0) void'(q[k].pop_front());
            end
            if (acc) begin
                if (m == 4'b0000) begin
                    if (m_drops < DMAX) m_drops++;
                end else begin
                    w.leaf_code = in_leaf_code;
                    w.payload   = in_payload;
                    for (int k = 0; k < NOUT; k++) begin
                        if (m[k]) q[k].push_back(w);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] code, input logic [31:0] pl);
        in_v         = 1'b1;
        in_leaf_code = code;
        in_payload   = pl;
        cycle();
    endtask

    initial begin
        bit pend;
        reset        = 1'b0;
        conf_route   = '0;
        in_v         = 1'b0;
        in_leaf_code = '0;
        in_payload   = '0;
        out_a        = '0;
        @(negedge clk);

        // Reset: in_a held low even with a valid word presented
        in_v = 1'b1;
        cycle();
        check("rst_in_a", obs_in_a, 1'b0);
        in_v = 1'b0;
        cycle();
        check("rst_out_v", out_v, 4'b0000);
        check("rst_fifo_count", fifo_count, 12'h000);
        check("rst_drop", drop_count, 4'h0);
        reset = 1'b1;

        // Fan-out with all outputs ready
        set_route(RO_ACC, 4'b0011);
        out_a = '1;
        send(RO_ACC, 32'h0000_1234);
        check("fan_in_a", obs_in_a, 1'b1);
        check("fan_out_v", out_v, 4'b0011);
        check("fan_data0", out_data[35:0], {RO_ACC, 32'h0000_1234});
        check("fan_data1", out_data[71:36], {RO_ACC, 32'h0000_1234});
        in_v = 1'b0;
        cycle();
        check("fan_drained", out_v, 4'b0000);

        // Backpressure isolation: output 1 stalled
        set_route(RO_ACC, 4'b0011);
        set_route(4'd3, 4'b0100);
        out_a = 4'b1101;
        for (int i = 0; i < 8; i++) begin
            send((i % 2 == 0) ? RO_ACC : 4'd3, $urandom);
            check("bp_accept", obs_in_a, 1'b1);
        end
        check("bp_count1", fifo_count[5:3], 3'd4);
        send(RO_ACC, 32'hCAFE_0005);
        check("bp_stall", obs_in_a, 1'b0);
        cycle();
        check("bp_stall_hold", obs_in_a, 1'b0);
        out_a = '1;
        cycle();
        check("bp_full_pop", obs_in_a, 1'b0);
        cycle();
        check("bp_release", obs_in_a, 1'b1);
        in_v = 1'b0;

        // Reset with partial occupancy
        out_a = '0;
        send(RO_ACC, 32'h1111_1111);
        send(RO_ACC, 32'h2222_2222);
        in_v  = 1'b0;
        reset = 1'b0;
        cycle();
        check("rst2_out_v", out_v, 4'b0000);
        check("rst2_fifo_count", fifo_count, 12'h000);
        check("rst2_drop", drop_count, 4'h0);
        reset = 1'b1;

        // Drop path and saturation
        set_route(4'd7, 4'b0000);
        out_a = '1;
        for (int i = 0; i < 3; i++) begin
            send(4'd7, $urandom);
            check("drop_in_a", obs_in_a, 1'b1);
            check("drop_out_v", out_v, 4'b0000);
        end
        check("drop_count3", drop_count, 4'd3);
        for (int i = 0; i < 17; i++) send(4'd7, $urandom);
        check("drop_sat", drop_count, 4'd15);
        in_v = 1'b0;

        // Full FIFO with simultaneous pop
        set_route(4'd5, 4'b0001);
        out_a = '0;
        for (int i = 0; i < 4; i++) send(4'd5, 32'hA000_0000 + i);
        check("fp_count4", fifo_count[2:0], 3'd4);
        out_a = 4'b0001;
        send(4'd5, 32'hA000_0004);
        check("fp_in_a0", obs_in_a, 1'b0);
        check("fp_count3", fifo_count[2:0], 3'd3);
        cycle();
        check("fp_in_a1", obs_in_a, 1'b1);
        check("fp_count3b", fifo_count[2:0], 3'd3);
        in_v = 1'b0;

        // Reset, then randomized traffic with source hold on stall
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        pend  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) conf_route = {$urandom, $urandom};
            if (!pend) begin
                in_v         = ($urandom_range(0, 3) != 0);
                in_leaf_code = 4'($urandom_range(0, 15));
                in_payload   = $urandom;
            end
            out_a = 4'($urandom_range(0, 15));
            cycle();
            pend = in_v && !obs_in_a;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
